// File: rtl/biu_seq_pkg.sv
// biu_seq_pkg: shared state encoding, size codes, word counts and MAR source codes for the BIU sequencer
package biu_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_XFER, S_DONE} state_t;
  localparam logic [1:0] SZ_1W = 2'b00;
  localparam logic [1:0] SZ_2W = 2'b01;
  localparam logic [1:0] SZ_VEC = 2'b10;
  localparam int WORDS_1 = 1;
  localparam int WORDS_2 = 2;
  localparam int WORDS_VEC = 8;
  localparam logic [3:0] SEL_REG = 4'd0;
  localparam logic [3:0] SEL_IP = 4'd1;
  localparam logic [3:0] SEL_SP = 4'd2;
  // size code 11 falls through to the single-word case
  function automatic logic [2:0] last_beat(input logic [1:0] size);
    return size == SZ_VEC ? 3'(WORDS_VEC - 1) : size == SZ_2W ? 3'(WORDS_2 - 1) : 3'(WORDS_1 - 1);
  endfunction
endpackage

// File: rtl/biu_bus_seq_if.sv
// biu_bus_seq_if: request, memory handshake and BIU control signals of the bus sequencer
interface biu_bus_seq_if;
  logic fetch_req, data_req, data_wr, data_addr_sp, mem_ready;
  logic [1:0] data_size;
  logic mar_ld, mar_inc, ir_ld, ip_inc, mem_rd, mem_wr, busy, fetch_done, data_done;
  logic [3:0] mar_sel;
  logic [1:0] rdbuf_ld, wrbuf_oe;
  logic [7:0] v_rdbuf_ld, v_wrbuf_oe;
  modport master (
    output fetch_req, data_req, data_wr, data_addr_sp, data_size, mem_ready,
    input mar_ld, mar_inc, ir_ld, ip_inc, mem_rd, mem_wr, busy, fetch_done, data_done,
    input mar_sel, rdbuf_ld, wrbuf_oe, v_rdbuf_ld, v_wrbuf_oe
  );
  modport slave (
    input fetch_req, data_req, data_wr, data_addr_sp, data_size, mem_ready,
    output mar_ld, mar_inc, ir_ld, ip_inc, mem_rd, mem_wr, busy, fetch_done, data_done,
    output mar_sel, rdbuf_ld, wrbuf_oe, v_rdbuf_ld, v_wrbuf_oe
  );
endinterface

// File: rtl/biu_beat_cnt.sv
// biu_beat_cnt: 3-bit beat counter with clear, increment and last-beat compare
module biu_beat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [2:0] last_i,
  output logic [2:0] cnt_o,
  output logic       last_o
);
  logic [2:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 3'd1;
  assign cnt_o = cnt_q;
  assign last_o = cnt_q == last_i;
endmodule

// File: rtl/biu_bus_seq.sv
// biu_bus_seq: arbitrates fetch/data requests and sequences address and per-beat memory transfers
module biu_bus_seq
  import biu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  biu_bus_seq_if.slave  bus
);
  state_t state_q, state_d;
  logic last_data_q, last_data_d, fetch_q, fetch_d, wr_q, wr_d, sp_q, sp_d, vec_q, vec_d;
  logic [2:0] last_q, last_d, beat;
  logic is_last, any_req, grant_data, xfer, done, rd_stb;
  assign any_req = bus.fetch_req | bus.data_req;
  // data wins unless it was served last and a fetch is waiting
  assign grant_data = bus.data_req & ~(last_data_q & bus.fetch_req);
  assign xfer = state_q == S_XFER;
  assign done = state_q == S_DONE;
  assign rd_stb = xfer & ~wr_q & bus.mem_ready;
  biu_beat_cnt u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == S_ADDR),
    .inc_i  (xfer & bus.mem_ready & ~is_last),
    .last_i (last_q),
    .cnt_o  (beat),
    .last_o (is_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_data_q <= 1'b0;
      fetch_q <= 1'b0;
      wr_q <= 1'b0;
      sp_q <= 1'b0;
      vec_q <= 1'b0;
      last_q <= '0;
    end else begin
      state_q <= state_d;
      last_data_q <= last_data_d;
      fetch_q <= fetch_d;
      wr_q <= wr_d;
      sp_q <= sp_d;
      vec_q <= vec_d;
      last_q <= last_d;
    end
  always_comb begin
    last_data_d = last_data_q;
    fetch_d = fetch_q;
    wr_d = wr_q;
    sp_d = sp_q;
    vec_d = vec_q;
    last_d = last_q;
    if (state_q == S_IDLE && any_req) begin
      last_data_d = grant_data;
      fetch_d = ~grant_data;
      wr_d = grant_data & bus.data_wr;
      sp_d = grant_data & bus.data_addr_sp;
      vec_d = grant_data & (bus.data_size == SZ_VEC);
      last_d = grant_data ? last_beat(bus.data_size) : 3'd0;
    end
    state_d = state_q == S_IDLE ? (any_req ? S_ADDR : S_IDLE) :
              state_q == S_ADDR ? S_XFER :
              state_q == S_XFER ? (bus.mem_ready & is_last ? S_DONE : S_XFER) : S_IDLE;
    bus.busy = state_q != S_IDLE;
    bus.mar_ld = state_q == S_ADDR;
    bus.mar_sel = state_q != S_ADDR ? SEL_REG : fetch_q ? SEL_IP : sp_q ? SEL_SP : SEL_REG;
    bus.mar_inc = xfer & bus.mem_ready & ~is_last;
    bus.mem_rd = xfer & ~wr_q;
    bus.mem_wr = xfer & wr_q;
    bus.ir_ld = rd_stb & fetch_q;
    bus.rdbuf_ld = rd_stb & ~fetch_q & ~vec_q ? 2'b01 << beat[0] : 2'b00;
    bus.v_rdbuf_ld = rd_stb & vec_q ? 8'b1 << beat : 8'b0;
    bus.wrbuf_oe = xfer & wr_q & ~vec_q ? 2'b01 << beat[0] : 2'b00;
    bus.v_wrbuf_oe = xfer & wr_q & vec_q ? 8'b1 << beat : 8'b0;
    bus.fetch_done = done & fetch_q;
    bus.ip_inc = done & fetch_q;
    bus.data_done = done & ~fetch_q;
  end
endmodule
